// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Execute stage plus the EX/MEM pipeline latch of the 16-bit pipelined CPU.
//   Operands arrive from the ID/EX latch. They can be replaced by forwarded
//   values from EX/MEM (the current out_ALU_result) or from MEM/WB (wb_data).
//   The ALU result, the forwarded store data, the pass-through control and the
//   destination register are registered for the MEM stage, which gives
//   one-cycle latency. The Z/V/N flag register also lives here.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   stall               hold the EX/MEM latch and the flags
//   flush               load a bubble into EX/MEM (ignored while stalled)
//   in_ALU_in1/in2      operands A and B from ID/EX
//   in_SW_data          store data from ID/EX
//   in_ALUOp            operation select
//   in_en_Z/V/N         per-flag update enables
//   in_MemRead .. in_HLT, in_RD   control and destination to pass down
//   fwd_a/fwd_b/fwd_sw  forward selects: 01 EX/MEM, 10 MEM/WB, else ID/EX
//   wb_data             MEM/WB writeback value
//   out_*               registered result, store data, control, destination
//   flag_Z/V/N          flag register read by the branch logic in ID

module ex_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] in_ALU_in1,
  input  logic [DW-1:0] in_ALU_in2,
  input  logic [DW-1:0] in_SW_data,
  input  logic [3:0]    in_ALUOp,
  input  logic          in_en_Z,
  input  logic          in_en_V,
  input  logic          in_en_N,
  input  logic          in_MemRead,
  input  logic          in_MemWrite,
  input  logic          in_MemToReg,
  input  logic          in_RegWrite,
  input  logic          in_HLT,
  input  logic [RW-1:0] in_RD,
  input  logic [1:0]    fwd_a,
  input  logic [1:0]    fwd_b,
  input  logic [1:0]    fwd_sw,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] out_ALU_result,
  output logic [DW-1:0] out_SW_data,
  output logic          out_MemRead,
  output logic          out_MemWrite,
  output logic          out_MemToReg,
  output logic          out_RegWrite,
  output logic          out_HLT,
  output logic [RW-1:0] out_RD,
  output logic          flag_Z,
  output logic          flag_V,
  output logic          flag_N
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_RED    = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;
  localparam logic [3:0] OP_LW     = 4'd8;
  localparam logic [3:0] OP_SW     = 4'd9;
  localparam logic [3:0] OP_LLB    = 4'd10;
  localparam logic [3:0] OP_LHB    = 4'd11;

  localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [DW-1:0]   op_s;
  logic [DW-1:0]   sum;
  logic [DW-1:0]   diff;
  logic            add_ovf;
  logic            sub_ovf;
  logic [9:0]      red_sum;
  logic [2*DW-1:0] rot_wide;
  logic [DW-1:0]   paddsb;
  logic [4:0]      nib_sum;
  logic [DW-1:0]   alu_result;
  logic            alu_ovf;
  logic            load_en;

  function automatic logic [DW-1:0] fwd_sel(input logic [1:0]    sel,
                                            input logic [DW-1:0] id_ex,
                                            input logic [DW-1:0] ex_mem,
                                            input logic [DW-1:0] mem_wb);
    case (sel)
      2'b01:   return ex_mem;
      2'b10:   return mem_wb;
      default: return id_ex;
    endcase
  endfunction

  // The EX/MEM forward taps the registered output. During a stall it
  // therefore sees the held value, which is the intended behaviour.
  assign op_a = fwd_sel(fwd_a,  in_ALU_in1, out_ALU_result, wb_data);
  assign op_b = fwd_sel(fwd_b,  in_ALU_in2, out_ALU_result, wb_data);
  assign op_s = fwd_sel(fwd_sw, in_SW_data, out_ALU_result, wb_data);

  // Overflow follows the usual sign rule. Saturation direction depends only
  // on A's sign: overflow is only possible when the result leaves A's
  // half of the range.
  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign add_ovf = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1]  != op_a[DW-1]);
  assign sub_ovf = (op_a[DW-1] != op_b[DW-1]) && (diff[DW-1] != op_a[DW-1]);

  // Four signed bytes sum to at most +/-512, so 10 bits are enough before
  // the result is sign-extended.
  assign red_sum = {{2{op_a[15]}}, op_a[15:8]} + {{2{op_a[7]}}, op_a[7:0]}
                 + {{2{op_b[15]}}, op_b[15:8]} + {{2{op_b[7]}}, op_b[7:0]};

  assign rot_wide = {op_a, op_a} >> op_b[3:0];

  // Each nibble lane is added at 5 bits. The lane overflowed when the top
  // two bits differ, and it then clamps toward the true sign.
  always_comb begin
    paddsb  = '0;
    nib_sum = '0;
    for (int i = 0; i < 4; i++) begin
      nib_sum = {op_a[4*i+3], op_a[4*i +: 4]} + {op_b[4*i+3], op_b[4*i +: 4]};
      if (nib_sum[4] != nib_sum[3])
        paddsb[4*i +: 4] = nib_sum[4] ? 4'h8 : 4'h7;
      else
        paddsb[4*i +: 4] = nib_sum[3:0];
    end
  end

  // ALU result select. alu_ovf is raised only for ADD and SUB and feeds the
  // V flag.
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (in_ALUOp)
      OP_ADD: begin
        alu_ovf    = add_ovf;
        alu_result = add_ovf ? (op_a[DW-1] ? SAT_NEG : SAT_POS) : sum;
      end
      OP_SUB: begin
        alu_ovf    = sub_ovf;
        alu_result = sub_ovf ? (op_a[DW-1] ? SAT_NEG : SAT_POS) : diff;
      end
      OP_XOR:        alu_result = op_a ^ op_b;
      OP_RED:        alu_result = {{(DW-10){red_sum[9]}}, red_sum};
      OP_SLL:        alu_result = op_a << op_b[3:0];
      OP_SRA:        alu_result = $signed(op_a) >>> op_b[3:0];
      OP_ROR:        alu_result = rot_wide[DW-1:0];
      OP_PADDSB:     alu_result = paddsb;
      OP_LW, OP_SW:  alu_result = {op_a[DW-1:1], 1'b0} + op_b;
      OP_LLB:        alu_result = {op_a[DW-1:8], op_b[7:0]};
      OP_LHB:        alu_result = {op_b[7:0], op_a[7:0]};
      default:       alu_result = '0;
    endcase
  end

  assign load_en = !stall && !flush;

  // Flag register. A flushed or stalled instruction must not disturb the
  // flags, so each flag needs its own enable and a live, unstalled slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_Z <= 1'b0;
      flag_V <= 1'b0;
      flag_N <= 1'b0;
    end else if (load_en) begin
      if (in_en_Z) flag_Z <= (alu_result == '0);
      if (in_en_V) flag_V <= alu_ovf;
      if (in_en_N) flag_N <= alu_result[DW-1];
    end
  end

  // EX/MEM latch. Stall wins over flush, so a flush raised during a stall
  // takes effect on the first unstalled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ALU_result <= '0;
      out_SW_data    <= '0;
      out_MemRead    <= 1'b0;
      out_MemWrite   <= 1'b0;
      out_MemToReg   <= 1'b0;
      out_RegWrite   <= 1'b0;
      out_HLT        <= 1'b0;
      out_RD         <= '0;
    end else if (!stall) begin
      if (flush) begin
        out_ALU_result <= '0;
        out_SW_data    <= '0;
        out_MemRead    <= 1'b0;
        out_MemWrite   <= 1'b0;
        out_MemToReg   <= 1'b0;
        out_RegWrite   <= 1'b0;
        out_HLT        <= 1'b0;
        out_RD         <= '0;
      end else begin
        out_ALU_result <= alu_result;
        out_SW_data    <= op_s;
        out_MemRead    <= in_MemRead;
        out_MemWrite   <= in_MemWrite;
        out_MemToReg   <= in_MemToReg;
        out_RegWrite   <= in_RegWrite;
        out_HLT        <= in_HLT;
        out_RD         <= in_RD;
      end
    end
  end

endmodule
